// File: rtl/safe_addsub_pipe.sv
// safe_addsub_pipe
// Two-stage pipelined fixed-point adder/subtractor with a runtime add/sub
// select, Q-format conversion (truncate or round-half-up), saturate-or-wrap
// output and a valid/ready handshake with backpressure.
// Stage 1 registers the exact full-scale sum; stage 2 rescales it to the
// output format and registers Q/overflow.
// Optional feature macro: SAFE_ADDSUB_OVF_CNT_EN builds the overflow counter
// and sticky flag; without it ovf_count/ovf_sticky read 0 and clr_ovf is
// ignored.
module safe_addsub_pipe #(
  parameter int A_WIDTH       = 16,
  parameter int A_FRAC        = 14,
  parameter int B_WIDTH       = 16,
  parameter int B_FRAC        = 14,
  parameter int Q_WIDTH       = 16,
  parameter int Q_FRAC        = 14,
  parameter int ROUND         = 0,
  parameter int SAT           = 1,
  parameter int OVF_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_WIDTH-1:0]       A,
  input  logic [B_WIDTH-1:0]       B,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_WIDTH-1:0]       Q,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     ovf_sticky,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

  // Full-scale format: one guard integer bit above the wider operand so the
  // sum (or difference, including -(most negative)) can never wrap.
  localparam int A_INT   = A_WIDTH - A_FRAC;
  localparam int B_INT   = B_WIDTH - B_FRAC;
  localparam int FS_INT  = ((A_INT > B_INT) ? A_INT : B_INT) + 1;
  localparam int FS_FRAC = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
  localparam int FS_W    = FS_INT + FS_FRAC;
  localparam int A_PAD   = FS_FRAC - A_FRAC;
  localparam int B_PAD   = FS_FRAC - B_FRAC;

  // Number of fraction bits dropped going to the output format (may be <= 0).
  localparam int D = FS_FRAC - Q_FRAC;

  // Width of the rescaled value in Q LSBs. When bits are dropped an extra
  // top bit is kept so that a rounding carry out of full scale is visible.
  localparam int V_W = (D > 0) ? (FS_W + 1 - D) : (FS_W - D);

  localparam logic [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_load;
  logic s1_load;

  assign s2_load  = ~out_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  // ---------------------------------------------------------------------
  // Stage 1: align operands and form the exact full-scale sum
  // ---------------------------------------------------------------------
  logic [FS_W-1:0] a_ext;
  logic [FS_W-1:0] b_ext;
  logic [FS_W-1:0] b_addend;
  logic [FS_W-1:0] sum_c;
  logic [FS_W-1:0] s1_sum_q, s1_sum_d;

  // Sign-extend, zero-pad fractions, and negate B in two's complement for sub
  always_comb begin
    a_ext    = {{(FS_W-A_WIDTH){A[A_WIDTH-1]}}, A} << A_PAD;
    b_ext    = {{(FS_W-B_WIDTH){B[B_WIDTH-1]}}, B} << B_PAD;
    b_addend = sub ? (~b_ext + FS_W'(1)) : b_ext;
    sum_c    = a_ext + b_addend;
  end

  // ---------------------------------------------------------------------
  // Stage 2: rescale the registered sum into Q LSBs
  // ---------------------------------------------------------------------
  logic [V_W-1:0]     s2_val;
  logic [Q_WIDTH-1:0] s2_q;
  logic               s2_ovf;

  generate
    if (D > 0) begin : g_drop
      // Full-scale sum with one extra sign bit so rounding cannot wrap.
      logic [FS_W:0] s_wide;
      if (ROUND != 0) begin : g_round
        localparam logic [FS_W:0] HALF = (FS_W+1)'(1) << (D - 1);
        // Round half up: add half an output LSB, then drop D LSBs
        always_comb begin
          s_wide = {s1_sum_q[FS_W-1], s1_sum_q} + HALF;
          s2_val = V_W'(s_wide >> D);
        end
      end else begin : g_trunc
        // Truncate: drop D LSBs (arithmetic, i.e. toward minus infinity)
        always_comb begin
          s_wide = {s1_sum_q[FS_W-1], s1_sum_q};
          s2_val = V_W'(s_wide >> D);
        end
      end
    end else begin : g_pad
      localparam int NEG_D = -D;
      // Output has at least as many fraction bits: append zeros
      always_comb s2_val = V_W'(s1_sum_q) << NEG_D;
    end

    if (V_W > Q_WIDTH) begin : g_narrow
      localparam int HI_W = V_W - Q_WIDTH + 1;
      logic [HI_W-1:0] hi;
      // Out of range when the bits above the Q sign bit are not a pure sign
      // extension; then clamp or keep the low bits depending on SAT
      always_comb begin
        hi     = s2_val[V_W-1:Q_WIDTH-1];
        s2_ovf = ~((&hi) | ~(|hi));
        if (s2_ovf && (SAT != 0)) begin
          s2_q = s2_val[V_W-1] ? Q_MIN : Q_MAX;
        end else begin
          s2_q = s2_val[Q_WIDTH-1:0];
        end
      end
    end else if (V_W == Q_WIDTH) begin : g_exact
      // Output is exactly as wide as the rescaled value: never overflows
      always_comb begin
        s2_ovf = 1'b0;
        s2_q   = s2_val;
      end
    end else begin : g_widen
      // Integer widening: sign-extend, never overflows
      always_comb begin
        s2_ovf = 1'b0;
        s2_q   = {{(Q_WIDTH-V_W){s2_val[V_W-1]}}, s2_val};
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------
  logic [Q_WIDTH-1:0] result_q, result_d;
  logic               overflow_q, overflow_d;

  // Advance each stage only when the stage downstream can take its data
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = sum_c;
      end
    end
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = s2_q;
        overflow_d = s2_ovf;
      end
    end
  end

  // Pipeline state; reset discards every in-flight sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Q         = result_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------
  // Overflow statistics
  // ---------------------------------------------------------------------
`ifdef SAFE_ADDSUB_OVF_CNT_EN
  logic [OVF_CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;
  logic                     ovf_sticky_q, ovf_sticky_d;
  logic                     ovf_xfer;

  // Count overflowing samples only as they are handed downstream; a clear in
  // the same cycle as such a transfer restarts the count at one
  always_comb begin
    ovf_xfer     = out_valid_q & out_ready & overflow_q;
    ovf_count_d  = ovf_count_q;
    ovf_sticky_d = ovf_sticky_q;
    if (clr_ovf) begin
      ovf_count_d  = '0;
      ovf_sticky_d = 1'b0;
    end
    if (ovf_xfer) begin
      ovf_sticky_d = 1'b1;
      if (clr_ovf) begin
        ovf_count_d = OVF_CNT_WIDTH'(1);
      end else if (~&ovf_count_q) begin
        ovf_count_d = ovf_count_q + OVF_CNT_WIDTH'(1);
      end
    end
  end

  // Counter and sticky state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_count_q  <= ovf_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_count  = ovf_count_q;
  assign ovf_sticky = ovf_sticky_q;
`else
  // Statistics not built: outputs read zero and the clear is ignored.
  logic clr_ovf_unused;
  assign clr_ovf_unused = clr_ovf;
  assign ovf_count      = '0;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_safe_addsub_pipe.sv
// Bench for safe_addsub_pipe: five differently configured instances share one
// input stream and one out_ready, each with its own scoreboard queue filled
// from an integer reference model at accept time and drained at transfer.
module tb_safe_addsub_pipe;

  // Instance configurations (index 0..4)
  int QW  [5] = '{16, 16, 14, 14, 20};
  int QF  [5] = '{14, 14, 12, 12, 15};
  int RND [5] = '{0,  0,  1,  0,  0};
  int SATP[5] = '{1,  0,  1,  0,  1};
  localparam int CNT_MAX = 3;  // u0 uses a 2-bit counter

`ifdef SAFE_ADDSUB_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        ovf;
    logic [19:0] q;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] A, B;
  logic        sub;
  logic        out_ready = 1'b1;
  logic        clr_ovf;
  int          mode;  // 0: out_ready=1, 1: out_ready=0, 2: random

  logic        in_ready0, in_ready1, in_ready2, in_ready3, in_ready4;
  logic        out_valid0, out_valid1, out_valid2, out_valid3, out_valid4;
  logic [15:0] q0, q1;
  logic [13:0] q2, q3;
  logic [19:0] q4;
  logic        ovf0, ovf1, ovf2, ovf3, ovf4;
  logic [1:0]  cnt0;
  logic        sticky0;
  logic [15:0] cnt_unused1, cnt_unused2, cnt_unused3, cnt_unused4;
  logic        sticky_unused1, sticky_unused2, sticky_unused3, sticky_unused4;

  exp_t sb0[$], sb1[$], sb2[$], sb3[$], sb4[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt_m    = 0;
  bit   sticky_m = 1'b0;

  always #5 clk = ~clk;

  // out_ready is changed 2 time units after the rising edge
  always @(posedge clk) begin
    #2;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = (($urandom & 32'h3) != 0);
    endcase
  end

  safe_addsub_pipe #(.SAT(1), .ROUND(0), .OVF_CNT_WIDTH(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(A), .B(B), .sub(sub),
    .out_valid(out_valid0), .out_ready(out_ready), .Q(q0), .overflow(ovf0),
    .clr_ovf(clr_ovf), .ovf_sticky(sticky0), .ovf_count(cnt0));
  safe_addsub_pipe #(.SAT(0), .ROUND(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready), .Q(q1), .overflow(ovf1),
    .clr_ovf(clr_ovf), .ovf_sticky(sticky_unused1), .ovf_count(cnt_unused1));
  safe_addsub_pipe #(.Q_WIDTH(14), .Q_FRAC(12), .ROUND(1), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B), .sub(sub),
    .out_valid(out_valid2), .out_ready(out_ready), .Q(q2), .overflow(ovf2),
    .clr_ovf(clr_ovf), .ovf_sticky(sticky_unused2), .ovf_count(cnt_unused2));
  safe_addsub_pipe #(.Q_WIDTH(14), .Q_FRAC(12), .ROUND(0), .SAT(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .A(A), .B(B), .sub(sub),
    .out_valid(out_valid3), .out_ready(out_ready), .Q(q3), .overflow(ovf3),
    .clr_ovf(clr_ovf), .ovf_sticky(sticky_unused3), .ovf_count(cnt_unused3));
  safe_addsub_pipe #(.Q_WIDTH(20), .Q_FRAC(15), .ROUND(0), .SAT(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .A(A), .B(B), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready), .Q(q4), .overflow(ovf4),
    .clr_ovf(clr_ovf), .ovf_sticky(sticky_unused4), .ovf_count(cnt_unused4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic in units of 2^-14, then rescale.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input int idx);
    int   av, bv, sum, sh, v, qmax, qmin, qv;
    exp_t e;
    av  = int'($signed(a));
    bv  = int'($signed(b));
    sum = s ? (av - bv) : (av + bv);
    sh  = 14 - QF[idx];
    if (sh > 0) v = (RND[idx] != 0) ? ((sum + (1 << (sh - 1))) >>> sh) : (sum >>> sh);
    else        v = sum * (1 << (-sh));
    qmax  = (1 << (QW[idx] - 1)) - 1;
    qmin  = -(1 << (QW[idx] - 1));
    e.ovf = (v > qmax) || (v < qmin);
    qv    = v;
    if (e.ovf && (SATP[idx] != 0)) qv = (v > qmax) ? qmax : qmin;
    e.q   = 20'(qv & ((1 << QW[idx]) - 1));
    return e;
  endfunction

  task automatic score(input int idx, input logic [19:0] got_q, input logic got_ovf,
                       output logic exp_ovf);
    exp_t e;
    int   n;
    case (idx)
      0: n = sb0.size();
      1: n = sb1.size();
      2: n = sb2.size();
      3: n = sb3.size();
      default: n = sb4.size();
    endcase
    $display("u%0d xfer Q=0x%0h ovf=%0b", idx, got_q, got_ovf);
    check($sformatf("u%0d_sb_nonempty", idx), 32'(n != 0), 32'd1);
    exp_ovf = 1'b0;
    if (n != 0) begin
      case (idx)
        0: e = sb0.pop_front();
        1: e = sb1.pop_front();
        2: e = sb2.pop_front();
        3: e = sb3.pop_front();
        default: e = sb4.pop_front();
      endcase
      check($sformatf("u%0d_Q", idx), 32'(got_q), 32'(e.q));
      check($sformatf("u%0d_overflow", idx), 32'(got_ovf), 32'(e.ovf));
      exp_ovf = e.ovf;
    end
  endtask

  // Monitor on the falling edge: counters, transfers, then accepts
  always @(negedge clk) begin
    logic e_ovf0, e_dummy;
    if (rst) begin
      cnt_m    = 0;
      sticky_m = 1'b0;
    end else begin
      check("ovf_count", 32'(cnt0), 32'(cnt_m));
      check("ovf_sticky", 32'(sticky0), 32'(sticky_m));
      e_ovf0 = 1'b0;
      if (out_valid0 && out_ready) score(0, 20'(q0), ovf0, e_ovf0);
      if (out_valid1 && out_ready) score(1, 20'(q1), ovf1, e_dummy);
      if (out_valid2 && out_ready) score(2, 20'(q2), ovf2, e_dummy);
      if (out_valid3 && out_ready) score(3, 20'(q3), ovf3, e_dummy);
      if (out_valid4 && out_ready) score(4, q4, ovf4, e_dummy);
      if (CNT_EN) begin
        if (clr_ovf) begin
          cnt_m    = 0;
          sticky_m = 1'b0;
        end
        if (out_valid0 && out_ready && e_ovf0) begin
          sticky_m = 1'b1;
          if (clr_ovf)              cnt_m = 1;
          else if (cnt_m < CNT_MAX) cnt_m = cnt_m + 1;
        end
      end
      if (in_valid && in_ready0) sb0.push_back(model(A, B, sub, 0));
      if (in_valid && in_ready1) sb1.push_back(model(A, B, sub, 1));
      if (in_valid && in_ready2) sb2.push_back(model(A, B, sub, 2));
      if (in_valid && in_ready3) sb3.push_back(model(A, B, sub, 3));
      if (in_valid && in_ready4) sb4.push_back(model(A, B, sub, 4));
    end
  end

  // Offer one sample; returns 1 time unit after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit acc;
    int guard;
    A = a; B = b; sub = s; in_valid = 1'b1;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready0;
      guard++;
      @(posedge clk); #1;
    end
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit empty;
    int guard;
    in_valid = 1'b0;
    mode     = 0;
    empty    = 1'b0;
    guard    = 0;
    while (!empty && guard < 100) begin
      @(negedge clk);
      empty = (sb0.size() == 0) && (sb1.size() == 0) && (sb2.size() == 0) &&
              (sb3.size() == 0) && (sb4.size() == 0) && !out_valid0;
      guard++;
    end
    check("drain_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
  endtask

  logic [15:0] bp_a[4], bp_b[4];
  logic        bp_s[4];

  initial begin
    exp_t e;
    int   idx, acc, guard;
    bit   took, seen;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; clr_ovf = 1'b0; mode = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_Q", 32'(q0), 32'd0);
    check("rst_overflow", 32'(ovf0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_ovf_count", 32'(cnt0), 32'd0);
    check("rst_ovf_sticky", 32'(sticky0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: out_valid exactly two edges after the accept
    send(16'h3000, 16'h3000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_out_valid", 32'(out_valid0), 32'd0);
    @(negedge clk);
    check("lat_cycle2_out_valid", 32'(out_valid0), 32'd1);
    @(posedge clk); #1;
    drain();

    // Directed corners, streamed back to back
    send(16'h7000, 16'h2000, 1'b0);  // 2.25: clamp / wrap
    send(16'h8000, 16'h8000, 1'b1);  // -2 - -2 = 0
    send(16'h0000, 16'h8000, 1'b1);  // 0 - -2 = +2: overflow
    send(16'h0003, 16'h0000, 1'b0);  // rounding vs truncation
    send(16'h7FFF, 16'h0000, 1'b0);  // rounds past max at Q2.12
    send(16'h8000, 16'h7FFF, 1'b0);  // -1 LSB
    send(16'h8000, 16'h0001, 1'b1);  // below min
    send(16'hFFFD, 16'h0000, 1'b0);  // negative rounding
    send(16'h4000, 16'hC000, 1'b1);  // 1 - -1 = 2: exactly one past max
    for (int i = 0; i < 30; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();

    // Backpressure: 5 stalled cycles, 4 samples offered
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom); bp_s[i] = 1'($urandom);
    end
    mode = 1;
    idx  = 0; acc = 0;
    A = bp_a[0]; B = bp_b[0]; sub = bp_s[0]; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = in_ready0;
      if (c >= 2) begin
        e = sb0[0];
        check("bp_hold_out_valid", 32'(out_valid0), 32'd1);
        check("bp_hold_Q", 32'(q0), 32'(e.q[15:0]));
        check("bp_hold_overflow", 32'(ovf0), 32'(e.ovf));
      end
      @(posedge clk); #1;
      if (took) begin
        acc++;
        idx++;
        if (idx < 4) begin A = bp_a[idx]; B = bp_b[idx]; sub = bp_s[idx]; end
      end
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready0), 32'd0);
    mode = 0;
    for (int i = idx; i < 4; i++) send(bp_a[i], bp_b[i], bp_s[i]);
    drain();

    // Random stream under random backpressure
    mode = 2;
    for (int i = 0; i < 60; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();

    // Overflow statistics
    pulse_clr();
    for (int i = 0; i < 5; i++) send(16'h7000, 16'h2000, 1'b0);
    drain();
    @(negedge clk);
    check("cnt_saturated", 32'(cnt0), CNT_EN ? 32'd3 : 32'd0);
    check("sticky_set", 32'(sticky0), CNT_EN ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    check("cnt_cleared", 32'(cnt0), 32'd0);
    check("sticky_cleared", 32'(sticky0), 32'd0);
    @(posedge clk); #1;
    send(16'h7000, 16'h2000, 1'b0);
    send(16'h0000, 16'h8000, 1'b1);
    drain();
    mode = 1;
    send(16'h7000, 16'h2000, 1'b0);
    in_valid = 1'b0;
    seen = 1'b0; guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clk);
      seen = out_valid0;
      guard++;
    end
    check("ovf_sample_waiting", 32'(seen), 32'd1);
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    mode    = 0;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    check("cnt_clr_with_xfer", 32'(cnt0), CNT_EN ? 32'd1 : 32'd0);
    check("sticky_clr_with_xfer", 32'(sticky0), CNT_EN ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset asserted with two samples in flight
    send(16'h1234, 16'h0111, 1'b0);
    send(16'h7000, 16'h2000, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete(); sb4.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid0), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready0), 32'd1);
    check("rst_mid_ovf_count", 32'(cnt0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_out_valid", 32'(out_valid0), 32'd0);
    end
    @(posedge clk); #1;
    send(16'hC000, 16'h1000, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
